// File: rtl/ifetcher_pkg.sv
// Shared definitions for the instruction fetcher stages: packet geometry,
// slot/offset widths and the issue FSM state encoding.
package ifetcher_pkg;

  localparam int IFETCHER_SLOTS = 4;
  localparam int SLOT_W         = 2;
  localparam int BYTE_OFF_W     = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } issue_state_e;

  function automatic int pkt_width(input int iw);
    return iw * IFETCHER_SLOTS;
  endfunction

endpackage

// File: rtl/ifetcher_slotmux.sv
// Combinational 4:1 slot selector: picks the slot-th instruction out of a
// fetch packet (slot 0 in the least significant IW bits).
module ifetcher_slotmux
  import ifetcher_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW*IFETCHER_SLOTS-1:0] pkt,
  input  logic [SLOT_W-1:0]            slot,
  output logic [IW-1:0]                inst
);

  logic [IW-1:0] lane [IFETCHER_SLOTS];

  generate
    for (genvar gi = 0; gi < IFETCHER_SLOTS; gi++) begin : g_lane
      assign lane[gi] = pkt[IW*gi +: IW];
    end
  endgenerate

  assign inst = lane[slot];

endmodule

// File: rtl/ifetcher_issue.sv
// Fetch issue stage: pops 4-instruction packets from the receive buffer and
// issues them one per cycle with PCs. Optional perf counters: IFETCHER_ISSUE_PERF_EN.
module ifetcher_issue
  import ifetcher_pkg::*;
#(
  parameter int IW = 32,
  parameter int AW = 32
) (
  input  logic                     iClk,
  input  logic                     iResetn,
  input  logic                     iClear,
  input  logic [AW-1:0]            iClearPC,
  input  logic [pkt_width(IW)-1:0] iRD,
  input  logic                     iEmpty,
  output logic                     oRE,
  output logic [IW-1:0]            oInst,
  output logic [AW-1:0]            oPC,
  output logic                     oValid,
  input  logic                     iReady
`ifdef IFETCHER_ISSUE_PERF_EN
  ,
  output logic [31:0]              oIssueCnt,
  output logic [31:0]              oStarveCnt
`endif
);

  localparam int BASE_W = AW - SLOT_W - BYTE_OFF_W;

  issue_state_e             state_reg, state_next;
  logic [pkt_width(IW)-1:0] hpkt_reg, hpkt_next;
  logic [SLOT_W-1:0]        slot_reg, slot_next;
  logic [SLOT_W-1:0]        sslot_reg, sslot_next;
  logic [BASE_W-1:0]        pbase_reg, pbase_next;

  logic xfer;
  logic last;
  logic re;
  logic unused_clear_pc_bits;

  assign unused_clear_pc_bits = ^iClearPC[BYTE_OFF_W-1:0];

  assign oValid = (state_reg == ST_VALID);
  assign xfer   = oValid & iReady;
  assign last   = xfer & (slot_reg == SLOT_W'(IFETCHER_SLOTS - 1));
  assign re     = iResetn & ~iClear & ~iEmpty & ((state_reg == ST_EMPTY) | last);
  assign oRE    = re;
  assign oPC    = {pbase_reg, slot_reg, {BYTE_OFF_W{1'b0}}};

  ifetcher_slotmux #(
    .IW(IW)
  ) u_slotmux (
    .pkt  (hpkt_reg),
    .slot (slot_reg),
    .inst (oInst)
  );

  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      state_reg <= ST_EMPTY;
      hpkt_reg  <= '0;
      slot_reg  <= '0;
      sslot_reg <= '0;
      pbase_reg <= '0;
    end else begin
      state_reg <= state_next;
      hpkt_reg  <= hpkt_next;
      slot_reg  <= slot_next;
      sslot_reg <= sslot_next;
      pbase_reg <= pbase_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hpkt_next  = hpkt_reg;
    slot_next  = slot_reg;
    sslot_next = sslot_reg;
    pbase_next = pbase_reg;
    if (iClear) begin
      // Redirect drops the held packet; the first packet after it starts mid-way.
      state_next = ST_EMPTY;
      pbase_next = iClearPC[AW-1:SLOT_W+BYTE_OFF_W];
      sslot_next = iClearPC[SLOT_W+BYTE_OFF_W-1:BYTE_OFF_W];
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (re) begin
            hpkt_next  = iRD;
            slot_next  = sslot_reg;
            sslot_next = '0;
            state_next = ST_VALID;
          end
        end
        ST_VALID: begin
          if (last) begin
            pbase_next = pbase_reg + BASE_W'(1);
            if (re) begin
              hpkt_next = iRD;
              slot_next = '0;
            end else begin
              state_next = ST_EMPTY;
            end
          end else if (xfer) begin
            slot_next = slot_reg + SLOT_W'(1);
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

`ifdef IFETCHER_ISSUE_PERF_EN
  logic [31:0] issue_cnt_reg;
  logic [31:0] starve_cnt_reg;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      issue_cnt_reg  <= '0;
      starve_cnt_reg <= '0;
    end else begin
      if (xfer) begin
        issue_cnt_reg <= issue_cnt_reg + 32'd1;
      end
      if ((state_reg == ST_EMPTY) && !iClear) begin
        starve_cnt_reg <= starve_cnt_reg + 32'd1;
      end
    end
  end

  assign oIssueCnt  = issue_cnt_reg;
  assign oStarveCnt = starve_cnt_reg;
`endif

endmodule

// File: tb/tb_ifetcher_issue.sv
// Randomized + directed bench for ifetcher_issue against an instruction-stream
// reference model (queue of pending {inst, pc} entries).
module tb_ifetcher_issue;
  localparam int IW = 32;
  localparam int AW = 32;

  logic            iClk = 1'b0;
  logic            iResetn;
  logic            iClear;
  logic [AW-1:0]   iClearPC;
  logic [IW*4-1:0] iRD;
  logic            iEmpty;
  logic            oRE;
  logic [IW-1:0]   oInst;
  logic [AW-1:0]   oPC;
  logic            oValid;
  logic            iReady;
`ifdef IFETCHER_ISSUE_PERF_EN
  logic [31:0]     oIssueCnt;
  logic [31:0]     oStarveCnt;
`endif

  ifetcher_issue #(.IW(IW), .AW(AW)) dut (
    .iClk     (iClk),
    .iResetn  (iResetn),
    .iClear   (iClear),
    .iClearPC (iClearPC),
    .iRD      (iRD),
    .iEmpty   (iEmpty),
    .oRE      (oRE),
    .oInst    (oInst),
    .oPC      (oPC),
    .oValid   (oValid),
    .iReady   (iReady)
`ifdef IFETCHER_ISSUE_PERF_EN
    ,
    .oIssueCnt  (oIssueCnt),
    .oStarveCnt (oStarveCnt)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } issue_t;

  logic [IW*4-1:0] fifo [$];
  issue_t          pend [$];
  logic [AW-1:0]   next_pc;
  logic [31:0]     issued;
  logic [31:0]     starve;
  logic            after_rst;
  int              n_checks;
  int              n_fail;
  int              seq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_buf();
    iEmpty = (fifo.size() == 0);
    iRD    = iEmpty ? '0 : fifo[0];
  endtask

  task automatic push_pkt(input logic [IW-1:0] s0, input logic [IW-1:0] s1,
                          input logic [IW-1:0] s2, input logic [IW-1:0] s3);
    fifo.push_back({s3, s2, s1, s0});
  endtask

  task automatic push_rand_pkt();
    push_pkt($urandom, $urandom, $urandom, $urandom);
  endtask

  // Model: a popped packet contributes its instructions from the entry slot to 3.
  task automatic load_pkt(input logic [IW*4-1:0] pkt);
    logic [AW-1:0] base;
    issue_t        e;
    base = next_pc & ~AW'(15);
    for (int k = int'(next_pc[3:2]); k < 4; k++) begin
      e.inst = pkt[k*IW +: IW];
      e.pc   = base + AW'(4 * k);
      pend.push_back(e);
    end
    next_pc = base + AW'(16);
  endtask

  task automatic step(input logic rstn, input logic clr, input logic [AW-1:0] cpc, input logic rdy);
    logic exp_valid;
    logic exp_re;
    logic [IW*4-1:0] pkt;
    iResetn  = rstn;
    iClear   = clr;
    iClearPC = cpc;
    iReady   = rdy;
    drive_buf();
    @(negedge iClk);
    exp_valid = (pend.size() != 0);
    exp_re    = rstn & ~clr & (fifo.size() != 0) & (!exp_valid | ((pend.size() == 1) & rdy));
    check("valid", {63'd0, oValid}, {63'd0, exp_valid});
    check("re", {63'd0, oRE}, {63'd0, exp_re});
    if (exp_valid) begin
      check("inst", 64'(oInst), 64'(pend[0].inst));
      check("pc", 64'(oPC), 64'(pend[0].pc));
    end
    if (after_rst) begin
      check("rst_inst", 64'(oInst), 64'd0);
      check("rst_pc", 64'(oPC), 64'd0);
      after_rst = 1'b0;
    end
`ifdef IFETCHER_ISSUE_PERF_EN
    check("issue_cnt", 64'(oIssueCnt), 64'(issued));
    check("starve_cnt", 64'(oStarveCnt), 64'(starve));
`endif
    @(posedge iClk);
    if (!rstn) begin
      pend.delete();
      next_pc   = '0;
      issued    = '0;
      starve    = '0;
      after_rst = 1'b1;
    end else if (clr) begin
      if (exp_valid && rdy) issued = issued + 32'd1;
      pend.delete();
      fifo.delete();
      next_pc = cpc;
    end else begin
      if (!exp_valid) starve = starve + 32'd1;
      if (exp_valid && rdy) begin
        void'(pend.pop_front());
        issued = issued + 32'd1;
      end
      if (exp_re) begin
        pkt = fifo.pop_front();
        load_pkt(pkt);
      end
    end
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    next_pc   = '0;
    issued    = '0;
    starve    = '0;
    after_rst = 1'b0;
    iResetn   = 1'b0;
    iClear    = 1'b0;
    iClearPC  = '0;
    iReady    = 1'b0;
    drive_buf();
    @(posedge iClk);
    #1;
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Single packet, then idle
    push_pkt(32'h1, 32'h2, 32'h3, 32'h4);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Two packets back-to-back
    push_rand_pkt();
    push_rand_pkt();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Redirect into the middle of a packet
    step(1'b1, 1'b1, 32'h1008, 1'b1);
    push_pkt(32'hA, 32'hB, 32'hC, 32'hD);
    push_rand_pkt();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Back-pressure during slot 1
    push_rand_pkt();
    push_rand_pkt();
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Redirect while at slot 2 with the buffer non-empty
    push_rand_pkt();
    push_rand_pkt();
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 32'h2000, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    push_rand_pkt();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Reset mid-packet
    push_rand_pkt();
    push_rand_pkt();
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Wrap of the packet base at the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFF4, 1'b1);
    push_rand_pkt();
    push_rand_pkt();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic          rstn;
      logic          clr;
      logic [AW-1:0] cpc;
      if (fifo.size() < 4 && $urandom_range(0, 99) < 35) push_rand_pkt();
      rstn = ($urandom_range(0, 499) != 0);
      clr  = ($urandom_range(0, 39) == 0);
      cpc  = $urandom & ~AW'(3);
      if ($urandom_range(0, 7) == 0) cpc = cpc | 32'hFFFF_FFF0;
      step(rstn, clr, cpc, ($urandom_range(0, 99) < 70));
    end

    seq = 0;
    while (pend.size() != 0 && seq < 64) begin
      step(1'b1, 1'b0, '0, 1'b1);
      seq++;
    end
    check("drain", 64'(pend.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetcher_issue.md
# ifetcher_issue

Instruction issue stage of the instruction fetcher: the read side of the fetch receive buffer. It pops 4-instruction fetch packets (IW*4 bits) from the receive buffer, slices each packet into single instructions with their PCs, and presents them to decode over a valid/ready handshake. It sustains one instruction per cycle across packet boundaries, and honours redirects (flush plus new PC) from the branch/exception path.

## Interface
- IW, 32, instruction width in bits
- AW, 32, PC width in bits; PCs are 4-byte aligned, packets are 16-byte aligned
- iClk  input  1  clock
- iResetn  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- iClear  input  1  redirect/flush; same signal that clears the receive buffer
- iClearPC  input  AW  redirect target PC, sampled when iClear=1
- iRD  input  IW*4  head packet of the receive buffer (combinational read); slot k = iRD[IW*(k+1)-1:IW*k]
- iEmpty  input  1  receive buffer empty
- oRE  output  1  pop receive buffer; packet on iRD is captured at the same edge
- oInst  output  IW  current instruction
- oPC  output  AW  PC of oInst
- oValid  output  1  oInst/oPC valid
- iReady  input  1  decode accepts; transfer = oValid & iReady

## Operation
- State: hold register hPkt (IW*4), slot counter slot[1:0], packet base pbase[AW-1:4], start slot sslot[1:0], FSM {EMPTY, VALID}.
- oInst = slot-th IW field of hPkt; oPC = {pbase, slot, 2'b00}; oValid = (state==VALID).
- last = oValid & iReady & (slot==3).
- oRE = iResetn & ~iClear & ~iEmpty & (state==EMPTY | last).
- EMPTY: on oRE -> hPkt<=iRD, slot<=sslot, sslot<=0, go VALID.
- VALID: transfer with slot!=3 -> slot<=slot+1. On last: pbase<=pbase+1; if oRE, load next packet with slot<=0 and stay VALID (no bubble); otherwise go EMPTY.
- No transfer -> all state held; oInst/oPC stable while oValid & ~iReady.
- iClear (priority over all): state<=EMPTY, pbase<=iClearPC[AW-1:4], sslot<=iClearPC[3:2]; oRE=0 that cycle; any held packet is discarded. The first packet after a redirect issues from sslot; slots below it are skipped without being presented.
- pbase wraps modulo 2^(AW-4).
- Reset: state=EMPTY, slot=0, sslot=0, pbase=0, hPkt=0; hence oValid=0, oInst=0, oPC=0; oRE=0 while iResetn=0.

## Timing
- Packet on iRD with iEmpty=0 in cycle N while EMPTY: oRE=1 in N; oValid=1 in N+1 with the first slot.
- Steady state: 4 instructions in 4 consecutive cycles per packet, continuous across packets when the buffer is non-empty at the last transfer.
- iClear in cycle N: oValid=0 in N+1. The earliest new oValid is N+2, given the buffer refills by N+1.
- Back-pressure: iReady=0 stalls with zero loss; oRE asserts only on the cycle of the final slot's transfer.

## Configuration
- IFETCHER_ISSUE_PERF_EN defined: adds outputs oIssueCnt[31:0] (counts transfers) and oStarveCnt[31:0] (counts cycles with state==EMPTY & ~iClear). Both counters clear on reset only, not on iClear, and wrap at 2^32.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package/include ifetcher_pkg: IFETCHER_SLOTS=4, slot index width 2, packet width IW*4, FSM state encodings, byte offset width 2.
- One sub-module, ifetcher_slotmux: 4:1 IW-bit slot selector (hPkt, slot -> oInst). It is purely combinational and is reused by the other fetcher stages.

## Test plan
- Reset then one packet {0x4,0x3,0x2,0x1} (slot0=0x1), iReady=1 -> oRE pulses once; oInst=0x1,0x2,0x3,0x4 on 4 consecutive cycles with oPC=0x0,0x4,0x8,0xC; then oValid=0.
- Two packets queued, iReady=1 -> 8 instructions back-to-back with no oValid gap; oRE high on cycle 0 and on the 4th transfer cycle; oPC runs 0x0..0x1C.
- iClear with iClearPC=0x1008, then packet {D,C,B,A} -> only C (oPC 0x1008) and D (oPC 0x100C) issue; the next packet starts at oPC 0x1010.
- iReady toggling 1,0,0,1 during slot 1 -> oInst/oPC held for the stall cycles; no instruction is lost or duplicated; oRE is not asserted early.
- iClear while VALID at slot 2, with iEmpty=0 -> oRE=0 that cycle; oValid=0 next cycle; the held remainder is never issued.
- iResetn low mid-packet while iReady=1 -> next cycle oValid=0, oPC=0, oRE=0. With IFETCHER_ISSUE_PERF_EN defined, oIssueCnt=0 after reset and increments by exactly 4 per fully issued packet.
